// File: rtl/m_issue_pkg.sv
// Shared types and constants for the M-extension issue controller.
package m_issue_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} m_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam int         CNT_W         = 8;

  // Saturating increment for the timeout counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/m_issue_ctrl_if.sv
// Coprocessor (PCPI) handshake between the EX-stage initiator and the M unit.
interface m_issue_ctrl_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic [4:0]  pcpi_rd;
  logic        pcpi_wr;
  logic [31:0] pcpi_result;
  logic        pcpi_busy;
  logic        pcpi_ready;
  logic [4:0]  pcpi_result_dest;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd,
    input  pcpi_wr, pcpi_result, pcpi_busy, pcpi_ready, pcpi_result_dest
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd,
    output pcpi_wr, pcpi_result, pcpi_busy, pcpi_ready, pcpi_result_dest
  );
endinterface

// File: rtl/m_insn_decode.sv
// RV32M detector for the EX stage; shared with the hazard unit.
import m_issue_pkg::*;

module m_insn_decode (
  input  logic        ex_valid,
  input  logic [31:0] ex_instruction,
  input  logic        ex_flush,
  output logic        is_m
);

  // Register/funct3 fields do not affect classification.
  logic unused_fields;
  assign unused_fields = ^ex_instruction[24:7];

  // A live, unflushed OP instruction with the MULDIV funct7.
  assign is_m = ex_valid && !ex_flush &&
                (ex_instruction[6:0]   == OPCODE_OP) &&
                (ex_instruction[31:25] == FUNCT7_MULDIV);

endmodule

// File: rtl/m_issue_ctrl.sv
// EX-stage initiator: launches RV32M ops on the coprocessor port, stalls
// until the unit answers, and returns one registered writeback beat.
import m_issue_pkg::*;

module m_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           ex_valid,
  input  logic [31:0]    ex_instruction,
  input  logic [31:0]    ex_rs1,
  input  logic [31:0]    ex_rs2,
  input  logic [4:0]     ex_rd,
  input  logic           ex_flush,
  m_issue_ctrl_if.master pcpi,
  output logic           m_stall,
  output logic           wb_valid,
  output logic [4:0]     wb_rd,
  output logic [31:0]    wb_data,
  output logic           m_timeout,
  output logic           m_dest_err
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  m_state_e         state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             to_hit;
  logic             wb_en;
  logic             is_m;

  // Busy is informational; the handshake is driven by ready alone.
  logic unused_busy;
  assign unused_busy = pcpi.pcpi_busy;

  m_insn_decode u_dec (
    .ex_valid       (ex_valid),
    .ex_instruction (ex_instruction),
    .ex_flush       (ex_flush),
    .is_m           (is_m)
  );

  assign cnt_inc = sat_inc(cnt);
  assign to_hit  = (cnt_inc >= TO_LIM);

  // Stall: held through ISSUE; in IDLE/DRAIN only an M op waits; never in reset.
  always_comb begin
    m_stall = 1'b0;
    if (!resetn) begin
      case (state)
        IDLE, DRAIN: m_stall = is_m;
        ISSUE:       m_stall = 1'b1;
        default:     m_stall = 1'b0;
      endcase
    end
  end

  // A redirect arriving in DONE kills the beat in the same cycle.
  assign wb_valid = (state == DONE) && wb_en && !ex_flush;

  // Issue state machine with operand latches, timeout counter and writeback regs.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      wb_en           <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      m_timeout       <= 1'b0;
      m_dest_err      <= 1'b0;
      pcpi.pcpi_valid <= 1'b0;
      pcpi.pcpi_insn  <= '0;
      pcpi.pcpi_rs1   <= '0;
      pcpi.pcpi_rs2   <= '0;
      pcpi.pcpi_rd    <= '0;
    end else begin
      m_timeout  <= 1'b0;
      m_dest_err <= 1'b0;
      case (state)
        IDLE: begin
          if (is_m) begin
            pcpi.pcpi_valid <= 1'b1;
            pcpi.pcpi_insn  <= ex_instruction;
            pcpi.pcpi_rs1   <= ex_rs1;
            pcpi.pcpi_rs2   <= ex_rs2;
            pcpi.pcpi_rd    <= ex_rd;
            cnt             <= '0;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt_inc;
          if (pcpi.pcpi_ready) begin
            wb_data         <= pcpi.pcpi_result;
            wb_rd           <= pcpi.pcpi_rd;
            wb_en           <= pcpi.pcpi_wr;
            m_dest_err      <= (pcpi.pcpi_result_dest != pcpi.pcpi_rd);
            pcpi.pcpi_valid <= 1'b0;
            state           <= DONE;
          end else if (ex_flush) begin
            // The unit cannot abort: keep the request up and swallow its answer.
            cnt   <= '0;
            state <= DRAIN;
          end else if (to_hit) begin
            m_timeout       <= 1'b1;
            wb_en           <= 1'b0;
            pcpi.pcpi_valid <= 1'b0;
            state           <= DONE;
          end
        end
        DRAIN: begin
          cnt <= cnt_inc;
          if (pcpi.pcpi_ready) begin
            pcpi.pcpi_valid <= 1'b0;
            state           <= IDLE;
          end else if (to_hit) begin
            m_timeout       <= 1'b1;
            pcpi.pcpi_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        DONE: begin
          wb_en <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Directed bench for m_issue_ctrl: a behavioural RV32M unit answers requests,
// and a per-cycle expectation timeline (built from the handshake timing rules)
// is checked against the DUT on every falling edge.
module tb_m_issue_ctrl;

  localparam int TO = 8;
  localparam int N  = 512;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_flush;
  logic [31:0] ex_instruction, ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic        m_stall, wb_valid, m_timeout, m_dest_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  m_issue_ctrl_if pcpi_bus();

  m_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_valid       (ex_valid),
    .ex_instruction (ex_instruction),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_flush       (ex_flush),
    .pcpi           (pcpi_bus),
    .m_stall        (m_stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .m_timeout      (m_timeout),
    .m_dest_err     (m_dest_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Expected-output timeline, zero (idle) unless a scenario marks otherwise.
  bit        e_stall [N];
  bit        e_pv    [N];
  bit        e_wbv   [N];
  bit        e_to    [N];
  bit        e_derr  [N];
  bit [4:0]  e_wbrd  [N];
  bit [31:0] e_wbdat [N];
  logic [31:0] cur_insn, cur_rs1, cur_rs2;
  logic [4:0]  cur_rd;

  // Behavioural M unit state.
  int          u_st = 0;
  int          u_left = 0;
  int          unit_lat = 1;
  int          unit_ovr = -1;
  bit          unit_dead = 1'b0;
  logic [31:0] u_insn, u_a, u_b;
  logic [4:0]  u_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] m_compute(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu;
    logic [63:0] ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'b0, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    case (insn[14:12])
      3'd0: begin p = ua * ub;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * sbu;  return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] r_insn(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, rd, op};
  endfunction

  // Unit answers once per request after unit_lat cycles of visible valid.
  task automatic unit_step();
    pcpi_bus.pcpi_ready = 1'b0;
    pcpi_bus.pcpi_wr    = 1'b0;
    if (resetn) begin
      u_st = 0;
      pcpi_bus.pcpi_busy = 1'b0;
      return;
    end
    case (u_st)
      0: if (pcpi_bus.pcpi_valid && !unit_dead) begin
        u_insn = pcpi_bus.pcpi_insn;
        u_a    = pcpi_bus.pcpi_rs1;
        u_b    = pcpi_bus.pcpi_rs2;
        u_rd   = pcpi_bus.pcpi_rd;
        u_left = unit_lat - 1;
        u_st   = 1;
        pcpi_bus.pcpi_busy = 1'b1;
      end
      1: u_left--;
      default: if (!pcpi_bus.pcpi_valid) u_st = 0;
    endcase
    if (u_st == 1 && u_left == 0) begin
      pcpi_bus.pcpi_ready       = 1'b1;
      pcpi_bus.pcpi_wr          = 1'b1;
      pcpi_bus.pcpi_result      = m_compute(u_insn, u_a, u_b);
      pcpi_bus.pcpi_result_dest = (unit_ovr >= 0) ? 5'(unit_ovr) : u_rd;
      pcpi_bus.pcpi_busy        = 1'b0;
      u_st = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    unit_step();
  endtask

  task automatic set_ex(input logic v, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic fl);
    ex_valid = v; ex_instruction = insn; ex_rs1 = a; ex_rs2 = b; ex_rd = rd; ex_flush = fl;
  endtask

  task automatic mark(input int kind, input int a, input int b);
    for (int c = a; c <= b; c++) begin
      if (c < N) begin
        if (kind == 0) e_stall[c] = 1'b1;
        else           e_pv[c]    = 1'b1;
      end
    end
  endtask

  task automatic set_cur(input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    cur_insn = insn; cur_rs1 = a; cur_rs2 = b; cur_rd = rd;
  endtask

  // Present an M op in the current cycle c0; unit answers in c0+lat, beat in c0+lat+1.
  task automatic issue_m(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input int ovr,
                         input logic [31:0] want);
    int c0;
    c0 = cyc;
    set_cur(insn, a, b, rd);
    unit_lat = lat;
    unit_ovr = ovr;
    mark(0, c0, c0 + lat);
    mark(1, c0 + 1, c0 + lat);
    e_wbv[c0+lat+1]   = 1'b1;
    e_wbrd[c0+lat+1]  = rd;
    e_wbdat[c0+lat+1] = want;
    if (ovr >= 0 && 5'(ovr) != rd) e_derr[c0+lat+1] = 1'b1;
    set_ex(1'b1, insn, a, b, rd, 1'b0);
    repeat (lat + 2) tick();
  endtask

  task automatic idle(input int n);
    set_ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (n) tick();
  endtask

  // Per-cycle comparison against the expectation timeline.
  always @(negedge clk) begin
    if (chk_on && cyc < N) begin
      chk("m_stall",    32'(m_stall),             32'(e_stall[cyc]));
      chk("pcpi_valid", 32'(pcpi_bus.pcpi_valid), 32'(e_pv[cyc]));
      chk("wb_valid",   32'(wb_valid),            32'(e_wbv[cyc]));
      chk("m_timeout",  32'(m_timeout),           32'(e_to[cyc]));
      chk("m_dest_err", 32'(m_dest_err),          32'(e_derr[cyc]));
      if (e_pv[cyc]) begin
        chk("pcpi_insn", pcpi_bus.pcpi_insn,    cur_insn);
        chk("pcpi_rs1",  pcpi_bus.pcpi_rs1,     cur_rs1);
        chk("pcpi_rs2",  pcpi_bus.pcpi_rs2,     cur_rs2);
        chk("pcpi_rd",   32'(pcpi_bus.pcpi_rd), 32'(cur_rd));
      end
      if (e_wbv[cyc]) begin
        chk("wb_rd",   32'(wb_rd), 32'(e_wbrd[cyc]));
        chk("wb_data", wb_data,    e_wbdat[cyc]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_pcpi_valid"}, 32'(pcpi_bus.pcpi_valid), 32'd0);
    chk({tag, "_pcpi_insn"},  pcpi_bus.pcpi_insn,       32'd0);
    chk({tag, "_pcpi_rs1"},   pcpi_bus.pcpi_rs1,        32'd0);
    chk({tag, "_pcpi_rs2"},   pcpi_bus.pcpi_rs2,        32'd0);
    chk({tag, "_pcpi_rd"},    32'(pcpi_bus.pcpi_rd),    32'd0);
    chk({tag, "_wb_valid"},   32'(wb_valid),            32'd0);
    chk({tag, "_wb_rd"},      32'(wb_rd),               32'd0);
    chk({tag, "_wb_data"},    wb_data,                  32'd0);
    chk({tag, "_m_timeout"},  32'(m_timeout),           32'd0);
    chk({tag, "_m_dest_err"}, 32'(m_dest_err),          32'd0);
    chk({tag, "_m_stall"},    32'(m_stall),             32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mul, mulh, mulhu, div, divu, rem, add, sub, opimm;
    int c0;
    mul   = r_insn(7'h01, 3'd0, 5'd5,  7'h33);
    mulh  = r_insn(7'h01, 3'd1, 5'd12, 7'h33);
    mulhu = r_insn(7'h01, 3'd3, 5'd7,  7'h33);
    div   = r_insn(7'h01, 3'd4, 5'd9,  7'h33);
    divu  = r_insn(7'h01, 3'd5, 5'd10, 7'h33);
    rem   = r_insn(7'h01, 3'd6, 5'd11, 7'h33);
    add   = r_insn(7'h00, 3'd0, 5'd4,  7'h33);
    sub   = r_insn(7'h20, 3'd0, 5'd4,  7'h33);
    opimm = r_insn(7'h01, 3'd0, 5'd4,  7'h13);

    pcpi_bus.pcpi_ready = 1'b0; pcpi_bus.pcpi_wr = 1'b0; pcpi_bus.pcpi_busy = 1'b0;
    pcpi_bus.pcpi_result = 32'h0; pcpi_bus.pcpi_result_dest = 5'd0;

    // Reset with an M op sitting in EX: stall must stay low.
    resetn = 1'b1;
    set_ex(1'b1, mul, 32'd7, 32'd3, 5'd5, 1'b0);
    tick(); tick();
    check_all_zero("reset");
    resetn = 1'b0;
    chk_on = 1'b1;
    idle(2);

    // Non-M traffic, M with ex_valid low, and M under a flush never issue.
    set_ex(1'b1, add,   32'd1, 32'd2, 5'd4, 1'b0); repeat (2) tick();
    set_ex(1'b1, sub,   32'd1, 32'd2, 5'd4, 1'b0); repeat (2) tick();
    set_ex(1'b1, opimm, 32'd1, 32'd2, 5'd4, 1'b0); repeat (2) tick();
    set_ex(1'b0, mul,   32'd1, 32'd2, 5'd4, 1'b0); repeat (2) tick();
    set_ex(1'b1, mul,   32'd1, 32'd2, 5'd4, 1'b1); repeat (2) tick();
    idle(1);

    // MUL 7 * -3 -> -21.
    issue_m(mul, 32'd7, 32'hFFFF_FFFD, 5'd5, 4, -1, 32'hFFFF_FFEB);
    // Back-to-back divide-by-zero cases, single-bubble spacing.
    issue_m(divu, 32'd100, 32'd0, 5'd10, 2, -1, 32'hFFFF_FFFF);
    issue_m(rem,  32'd100, 32'd0, 5'd11, 1, -1, 32'd100);
    // rd = x0 still yields a beat.
    issue_m(r_insn(7'h01, 3'd0, 5'd0, 7'h33), 32'd3, 32'd5, 5'd0, 2, -1, 32'd15);
    idle(1);
    // Unit reports destination 6 for rd 5.
    issue_m(mul, 32'd2, 32'd3, 5'd5, 3, 6, 32'd6);
    idle(1);
    // Ready lands on the same cycle the timeout would fire: ready wins.
    issue_m(mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, TO, -1, 32'hFFFF_FFFE);
    idle(1);

    // Ready and flush together, flush held into DONE: no drain, no beat.
    c0 = cyc;
    set_cur(mul, 32'd3, 32'd4, 5'd5);
    unit_lat = 3; unit_ovr = -1;
    mark(0, c0, c0 + 3);
    mark(1, c0 + 1, c0 + 3);
    set_ex(1'b1, mul, 32'd3, 32'd4, 5'd5, 1'b0);
    repeat (3) tick();
    set_ex(1'b1, mul, 32'd3, 32'd4, 5'd5, 1'b1);
    repeat (2) tick();
    idle(1);

    // DIV overflow flushed 3 cycles in; ADD flows during DRAIN; then MULH.
    c0 = cyc;
    set_cur(div, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    unit_lat = 8; unit_ovr = -1;
    mark(0, c0, c0 + 3);
    mark(1, c0 + 1, c0 + 8);
    set_ex(1'b1, div, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
    repeat (3) tick();
    set_ex(1'b1, div, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1);
    tick();
    set_ex(1'b1, add, 32'd1, 32'd2, 5'd4, 1'b0);
    repeat (5) tick();
    issue_m(mulh, 32'h8000_0000, 32'd2, 5'd12, 3, -1, 32'hFFFF_FFFF);
    idle(1);

    // Silent unit in ISSUE: timeout pulse TO+1 cycles after issue, no beat.
    c0 = cyc;
    unit_dead = 1'b1;
    set_cur(mul, 32'd9, 32'd9, 5'd5);
    mark(0, c0, c0 + TO);
    mark(1, c0 + 1, c0 + TO);
    e_to[c0+TO+1] = 1'b1;
    set_ex(1'b1, mul, 32'd9, 32'd9, 5'd5, 1'b0);
    repeat (TO + 2) tick();
    idle(1);
    unit_dead = 1'b0;

    // Silent unit after a flush: DRAIN times out on its own fresh count.
    c0 = cyc;
    unit_dead = 1'b1;
    set_cur(mul, 32'd5, 32'd6, 5'd8);
    mark(0, c0, c0 + 3);
    mark(1, c0 + 1, c0 + 3 + TO);
    e_to[c0+4+TO] = 1'b1;
    set_ex(1'b1, mul, 32'd5, 32'd6, 5'd8, 1'b0);
    repeat (3) tick();
    set_ex(1'b1, mul, 32'd5, 32'd6, 5'd8, 1'b1);
    tick();
    set_ex(1'b1, add, 32'd1, 32'd2, 5'd4, 1'b0);
    repeat (TO) tick();
    idle(1);
    unit_dead = 1'b0;

    // Reset in the third ISSUE cycle; next cycle everything is cleared.
    c0 = cyc;
    set_cur(mul, 32'd11, 32'd13, 5'd5);
    unit_lat = 7; unit_ovr = -1;
    mark(0, c0, c0 + 2);
    mark(1, c0 + 1, c0 + 3);
    set_ex(1'b1, mul, 32'd11, 32'd13, 5'd5, 1'b0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    set_ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check_all_zero("midreset");
    tick();
    issue_m(mul, 32'd7, 32'hFFFF_FFFD, 5'd5, 3, -1, 32'hFFFF_FFEB);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
